timer_bank: RTL and testbench
=============================

# timer_bank

Multi-channel programmable down-timer bank for game-logic timing: duck flight duration, spawn intervals, round timeouts. Each of `N_CH` independent channels counts down a loaded value on a shared prescaled tick. On expiry a channel emits a one-cycle `done` pulse. A channel then either stops (one-shot) or reloads itself (periodic). Sits between the game controller FSM and the frame/clock domain. Replaces single-channel down counters.

## Interface

- `N_CH`, default 4: number of independent timer channels.
- `W`, default 16: counter width per channel.
- `PRESCALE`, default 1: clocks per tick. Must be ≥ 1; 1 means a tick on every clock.

- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `ld`, in, `N_CH`: per-channel load strobe.
- `data_in`, in, `N_CH*W`: load value; channel i uses `[i*W +: W]`.
- `periodic`, in, `N_CH`: mode, sampled only with `ld`. 1 = auto-reload, 0 = one-shot.
- `en`, in, `N_CH`: level; a channel decrements only on ticks while high.
- `clr`, in, `N_CH`: per-channel abort strobe.
- `done`, out, `N_CH`: registered one-cycle expiry pulse.
- `busy`, out, `N_CH`: channel is in RUN.
- `count`, out, `N_CH*W`: current count of each channel, same packing as `data_in`.

## Operation

- **Prescaler**
  - `pre` counts 0..`PRESCALE`-1 and wraps.
  - `tick` = (`pre` == `PRESCALE`-1). With `PRESCALE`=1, `tick` is constantly 1.
  - The prescaler is free-running, shared by all channels, and unaffected by `ld`/`clr`.
- **Per-channel state**
  - Per channel: `state` {IDLE, RUN}, `cnt[W]`, `reload[W]`, `mode`.
- **Per-channel priority each edge:** `reset` > `clr` > `ld` > countdown.
  - `clr`: state←IDLE, cnt←0, done←0.
  - `ld`: cnt←data_in, reload←data_in, mode←periodic, state←RUN, done←0.
    - Reloading a running channel restarts it.
  - RUN, `en` & `tick`, cnt≠0: cnt←cnt−1, done←0.
  - RUN, `en` & `tick`, cnt==0: done←1.
    - If mode=1: cnt←reload, stay RUN.
    - If mode=0: state←IDLE, cnt stays 0.
  - Any other case: cnt/state hold, done←0.
    - `done` is never held for more than one cycle.
- **IDLE behaviour:** `en` is ignored; `count` holds its value.
- **Expiry length:** a load of value D expires after exactly D+1 enabled ticks. Load of 0 expires on the first enabled tick.
- **Periodic reload of 0:** a periodic channel loaded with 0 pulses `done` on every enabled tick.
- **Channel independence:** channels never interact except through the shared tick.
- **Wrap-around:** no underflow wrap is possible; cnt==0 is always expiry, never a decrement.
- **Arithmetic:** all arithmetic is W-bit unsigned.

## Timing

- **Reset values** (after a `reset` edge): `done`=0, `busy`=0, `count`=0, `pre`=0, all channels IDLE, `reload`=0, `mode`=0.
- **Load latency:** `busy` and `count` reflect a load in the cycle after the `ld` edge.
- **`PRESCALE`=1, `en` held high, `ld` with D at edge k:**
  - `count` = D−j after edge k+j, for j ≤ D.
  - `done` is high for exactly the cycle after edge k+D+1.
  - One-shot: `busy` drops at that same edge.
- **`PRESCALE`=P>1:** first tick comes 1..P cycles after the load, depending on prescaler phase. Expiry lands between D·P+1 and (D+1)·P cycles after the load edge.
- **Periodic spacing:** successive `done` pulses are exactly (D+1)·P cycles apart while `en` stays high.
- **Pausing:** deasserting `en` freezes `cnt`. Ticks missed while paused are not replayed.
- **Simultaneous strobes:**
  - `ld` and `clr` same cycle: `clr` wins.
  - `ld` on the expiry cycle: the load wins and `done` is not pulsed.
- **Reset mid-count:** aborts all channels, with no `done` pulse.
- **Combinational paths:** no input reaches any output combinationally.

## Test plan

- **One-shot basic:** reset; `PRESCALE`=1; ch0 `ld` D=3, periodic=0, `en`=1.
  - Required: `count` 3,2,1,0; `done[0]` high only on the 5th cycle after load; `busy[0]` 0 afterward; `count` stays 0.
- **Periodic + pause:** ch1 D=2, periodic=1, `en`=1.
  - Required: `done[1]` pulses every 3 cycles.
  - Drop `en` 4 cycles mid-count: next pulse is delayed by exactly 4 cycles.
- **Prescaler:** `PRESCALE`=4, ch2 D=1 loaded when `pre`=0.
  - Required: `done[2]` 8 cycles after load; `count` changes only on ticks.
- **Zero and edge loads:**
  - D=0 one-shot: `done` after 1 tick.
  - D=2^W−1: no wrap; `done` after 2^W ticks.
  - Periodic D=0: `done` high on consecutive tick cycles.
- **Priority collisions:**
  - `ld`+`clr` same edge: IDLE, count 0.
  - `ld` D=5 on the cycle ch3 would expire: no `done`; `count`=5.
  - `clr` while running: no `done`.
- **Reset mid-operation and independence:** all 4 channels running with different D values; assert `reset` one cycle.
  - Required: all outputs 0, no `done`.
  - Before the reset, each channel's `done` timing must be unaffected by strobes to the other channels.

Source files
------------

// File: rtl/timer_bank_if.sv
// Control/status bundle between the game controller and the timer bank.
// The controller drives strobes and load data; the bank returns per-channel status.
interface timer_bank_if #(
    parameter int N_CH = 4,
    parameter int W    = 16
);
    logic [N_CH-1:0]   ld;
    logic [N_CH*W-1:0] data_in;
    logic [N_CH-1:0]   periodic;
    logic [N_CH-1:0]   en;
    logic [N_CH-1:0]   clr;
    logic [N_CH-1:0]   done;
    logic [N_CH-1:0]   busy;
    logic [N_CH*W-1:0] count;

    modport master (
        output ld, data_in, periodic, en, clr,
        input  done, busy, count
    );

    modport slave (
        input  ld, data_in, periodic, en, clr,
        output done, busy, count
    );
endinterface

// File: rtl/timer_bank.sv
// Bank of N_CH independent down-timers sharing one free-running prescaled tick.
// Each channel pulses done for one cycle on expiry, then stops or reloads.
module timer_bank #(
    parameter int N_CH     = 4,
    parameter int W        = 16,
    parameter int PRESCALE = 1
) (
    input logic         clk,
    input logic         reset,
    timer_bank_if.slave bus
);
    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    logic [PW-1:0]     r_pre;
    logic              w_tick;
    logic [N_CH-1:0]   w_done;
    logic [N_CH-1:0]   w_busy;
    logic [N_CH*W-1:0] w_count;

    // Shared prescaler: never disturbed by channel strobes, so tick phase is global.
    assign w_tick = (r_pre == PRE_LAST);

    always_ff @(posedge clk) begin
        if (reset || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_e         r_state, w_state_nxt;
        logic [W-1:0]   r_cnt, w_cnt_nxt;
        logic [W-1:0]   r_reload, w_reload_nxt;
        logic           r_mode, w_mode_nxt;
        logic           r_done, w_done_nxt;
        logic [W-1:0]   w_din;

        assign w_din = bus.data_in[g*W +: W];

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state  <= S_IDLE;
                r_cnt    <= '0;
                r_reload <= '0;
                r_mode   <= 1'b0;
                r_done   <= 1'b0;
            end else begin
                r_state  <= w_state_nxt;
                r_cnt    <= w_cnt_nxt;
                r_reload <= w_reload_nxt;
                r_mode   <= w_mode_nxt;
                r_done   <= w_done_nxt;
            end
        end

        // clr beats ld beats countdown; cnt==0 on a tick is expiry, never a decrement.
        always_comb begin
            w_state_nxt  = r_state;
            w_cnt_nxt    = r_cnt;
            w_reload_nxt = r_reload;
            w_mode_nxt   = r_mode;
            w_done_nxt   = 1'b0;
            if (bus.clr[g]) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end else if (bus.ld[g]) begin
                w_state_nxt  = S_RUN;
                w_cnt_nxt    = w_din;
                w_reload_nxt = w_din;
                w_mode_nxt   = bus.periodic[g];
            end else if (r_state == S_RUN && bus.en[g] && w_tick) begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - W'(1);
                end else begin
                    w_done_nxt = 1'b1;
                    if (r_mode) begin
                        w_cnt_nxt = r_reload;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
        end

        assign w_done[g]          = r_done;
        assign w_busy[g]          = (r_state == S_RUN);
        assign w_count[g*W +: W]  = r_cnt;
    end

    assign bus.done  = w_done;
    assign bus.busy  = w_busy;
    assign bus.count = w_count;
endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank: one PRESCALE=1/W=16 instance and one PRESCALE=4/W=6 instance.
// Expected done cycles are queued at load time and matched when done pulses appear.
module tb_timer_bank;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    timer_bank_if #(.N_CH(4), .W(16)) bus1 ();
    timer_bank_if #(.N_CH(4), .W(6))  bus4 ();

    timer_bank #(.N_CH(4), .W(16), .PRESCALE(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    timer_bank #(.N_CH(4), .W(6),  .PRESCALE(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    typedef struct {
        int ch;
        int cyc;
    } exp_t;

    exp_t sb1[$];
    exp_t sb4[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic push1(input int ch, input int t);
        exp_t e;
        e.ch = ch; e.cyc = t;
        sb1.push_back(e);
    endtask

    task automatic push4(input int ch, input int t);
        exp_t e;
        e.ch = ch; e.cyc = t;
        sb4.push_back(e);
    endtask

    task automatic sb_pop(input int d, input int ch);
        int idx;
        idx = -1;
        if (d == 1) begin
            foreach (sb1[i]) if (idx < 0 && sb1[i].ch == ch) idx = i;
            if (idx < 0) chk($sformatf("dut1_ch%0d_unexpected_done_at_%0d", ch, cyc), 1, 0);
            else begin
                chk($sformatf("dut1_ch%0d_done_cycle", ch), cyc, sb1[idx].cyc);
                sb1.delete(idx);
            end
        end else begin
            foreach (sb4[i]) if (idx < 0 && sb4[i].ch == ch) idx = i;
            if (idx < 0) chk($sformatf("dut4_ch%0d_unexpected_done_at_%0d", ch, cyc), 1, 0);
            else begin
                chk($sformatf("dut4_ch%0d_done_cycle", ch), cyc, sb4[idx].cyc);
                sb4.delete(idx);
            end
        end
    endtask

    // cyc = number of rising edges seen; done sampled 1 time unit after each edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        for (int ch = 0; ch < 4; ch++) begin
            if (bus1.done[ch] === 1'b1) sb_pop(1, ch);
            if (bus4.done[ch] === 1'b1) sb_pop(4, ch);
        end
    end

    function automatic logic [15:0] cnt1(input int ch);
        return bus1.count[ch*16 +: 16];
    endfunction

    function automatic logic [5:0] cnt4(input int ch);
        return bus4.count[ch*6 +: 6];
    endfunction

    task automatic at(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic ld1(input int ch, input int d, input bit per);
        bus1.ld[ch]             = 1'b1;
        bus1.data_in[ch*16 +: 16] = 16'(d);
        bus1.periodic[ch]       = per;
    endtask

    task automatic ld4(input int ch, input int d, input bit per);
        bus4.ld[ch]             = 1'b1;
        bus4.data_in[ch*6 +: 6] = 6'(d);
        bus4.periodic[ch]       = per;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int r;
        reset = 1'b1;
        bus1.ld = '0; bus1.data_in = '0; bus1.periodic = '0; bus1.en = '0; bus1.clr = '0;
        bus4.ld = '0; bus4.data_in = '0; bus4.periodic = '0; bus4.en = '0; bus4.clr = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_done1", bus1.done, 0);
        chk("rst_busy1", bus1.busy, 0);
        chk("rst_count1", bus1.count, 0);
        chk("rst_done4", bus4.done, 0);
        chk("rst_busy4", bus4.busy, 0);
        chk("rst_count4", bus4.count, 0);
        bus1.en = 4'hF;
        bus4.en = 4'hF;

        // One-shot D=3 on ch0
        c = cyc; ld1(0, 3, 1'b0); push1(0, c + 5);
        at(c + 1); bus1.ld = '0;
        chk("os_count_j0", cnt1(0), 3);
        chk("os_busy_run", bus1.busy[0], 1);
        at(c + 2); chk("os_count_j1", cnt1(0), 2);
        at(c + 3); chk("os_count_j2", cnt1(0), 1);
        at(c + 4); chk("os_count_j3", cnt1(0), 0);
        chk("os_busy_before_exp", bus1.busy[0], 1);
        at(c + 5); chk("os_busy_after_exp", bus1.busy[0], 0);
        at(c + 6); chk("os_count_stays0", cnt1(0), 0);
        chk("os_done_one_cycle", bus1.done[0], 0);

        // Periodic D=2 on ch1 with a 4-cycle pause
        c = cyc; ld1(1, 2, 1'b1);
        push1(1, c + 4); push1(1, c + 7); push1(1, c + 14); push1(1, c + 17);
        at(c + 1); bus1.ld = '0;
        at(c + 8); chk("per_count_pause_start", cnt1(1), 1);
        bus1.en[1] = 1'b0;
        at(c + 12); chk("per_count_frozen", cnt1(1), 1);
        bus1.en[1] = 1'b1;
        at(c + 18); bus1.clr[1] = 1'b1;
        at(c + 19); bus1.clr = '0;
        chk("clr_run_busy", bus1.busy[1], 0);
        chk("clr_run_count", cnt1(1), 0);

        // Zero loads: periodic D=0 on ch2, one-shot D=0 on ch3
        c = cyc; ld1(2, 0, 1'b1); ld1(3, 0, 1'b0);
        push1(2, c + 2); push1(2, c + 3); push1(2, c + 4); push1(2, c + 5);
        push1(3, c + 2);
        at(c + 1); bus1.ld = '0;
        at(c + 5); bus1.clr[2] = 1'b1;
        at(c + 6); bus1.clr = '0;
        chk("zero_busy_ch2", bus1.busy[2], 0);
        chk("zero_busy_ch3", bus1.busy[3], 0);

        // ld and clr on the same edge
        ld1(3, 7, 1'b0); bus1.clr[3] = 1'b1;
        @(negedge clk); bus1.ld = '0; bus1.clr = '0;
        chk("ldclr_busy", bus1.busy[3], 0);
        chk("ldclr_count", cnt1(3), 0);

        // Load landing on the expiry edge suppresses done
        c = cyc; ld1(3, 1, 1'b0);
        at(c + 1); bus1.ld = '0;
        at(c + 2); ld1(3, 5, 1'b0); push1(3, c + 9);
        at(c + 3); bus1.ld = '0;
        chk("ldexp_count", cnt1(3), 5);
        chk("ldexp_busy", bus1.busy[3], 1);
        chk("ldexp_no_done", bus1.done[3], 0);
        at(c + 10); chk("ldexp_busy_after", bus1.busy[3], 0);

        // Independence under neighbour strobes, then reset mid-count
        c = cyc; ld1(0, 6, 1'b0); push1(0, c + 8);
        at(c + 1); bus1.ld = '0;
        at(c + 2); ld1(1, 3, 1'b0); push1(1, c + 7);
        at(c + 3); bus1.ld = '0; ld1(3, 20, 1'b1);
        at(c + 4); bus1.ld = '0; ld1(2, 50, 1'b0);
        at(c + 5); bus1.ld = '0; bus1.clr[2] = 1'b1;
        at(c + 6); bus1.clr = '0; ld1(2, 50, 1'b0);
        at(c + 7); bus1.ld = '0;
        at(c + 10); ld1(0, 100, 1'b0); ld1(1, 100, 1'b1);
        at(c + 11); bus1.ld = '0;
        chk("ind_busy_all", bus1.busy, 4'hF);
        chk("ind_count_ch3", cnt1(3), 13);
        chk("ind_count_ch2", cnt1(2), 46);
        at(c + 12); reset = 1'b1;
        at(c + 13); reset = 1'b0;
        r = cyc;
        chk("midrst_done", bus1.done, 0);
        chk("midrst_busy", bus1.busy, 0);
        chk("midrst_count", bus1.count, 0);

        // PRESCALE=4: load on an edge that leaves the prescaler at 0
        while (((cyc + 1 - r) % 4) != 0) @(negedge clk);
        c = cyc;
        ld4(2, 1, 1'b0);  push4(2, c + 9);
        ld4(1, 0, 1'b0);  push4(1, c + 5);
        ld4(0, 63, 1'b0); push4(0, c + 257);
        at(c + 1); bus4.ld = '0;
        chk("pre_count_load", cnt4(2), 1);
        chk("pre_count_max_load", cnt4(0), 63);
        at(c + 4); chk("pre_count_no_tick", cnt4(2), 1);
        at(c + 5); chk("pre_count_tick", cnt4(2), 0);
        at(c + 6); chk("pre_zero_busy", bus4.busy[1], 0);
        at(c + 130); chk("pre_max_mid", cnt4(0), 31);
        at(c + 254); chk("pre_max_at0", cnt4(0), 0);
        chk("pre_max_busy", bus4.busy[0], 1);
        at(c + 260); chk("pre_max_done_busy", bus4.busy, 0);
        chk("pre_max_count", cnt4(0), 0);

        chk("sb1_missing_done", sb1.size(), 0);
        chk("sb4_missing_done", sb4.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
